split_sample_gen: RTL and testbench

//   Candidate-vector generator that sits directly upstream of a split constraint stage.

---
 rtl/split_sample_gen.sv | 184 ++++++++++++++++++
 tb/tb_split_sample_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/split_sample_gen.sv
`default_nettype none
// ============================================================================
// Module      : split_sample_gen
// Description : LFSR-driven candidate generator feeding a split constraint
//               stage; counts satisfying samples until target or budget hit.
// Revision    : 1.0 - initial release
// ============================================================================
module split_sample_gen #(
    parameter int VEC_W = 368,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] target,
    input  logic [31:0]      max_tries,
    output logic [VEC_W-1:0] cand_vec,
    output logic             cand_valid,
    input  logic             cand_ready,
    input  logic             chk_valid,
    input  logic             chk_x,
    output logic [VEC_W-1:0] sol_vec,
    output logic             sol_valid,
    output logic [CNT_W-1:0] sol_count,
    output logic [31:0]      try_count,
    output logic             busy,
    output logic             done,
    output logic             exhausted
);

    localparam int WORDS = (VEC_W + 31) / 32;
    localparam int WC_W  = $clog2(WORDS + 1);
    localparam logic [WC_W-1:0] c_LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [31:0]     c_LFSR_TAPS = 32'h8020_0003;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_OFFER = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic [VEC_W-1:0] cand_vec_q, cand_vec_d;
    logic             cand_valid_q, cand_valid_d;
    logic [VEC_W-1:0] sol_vec_q, sol_vec_d;
    logic             sol_valid_q, sol_valid_d;
    logic [CNT_W-1:0] sol_count_q, sol_count_d;
    logic [31:0]      try_count_q, try_count_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [31:0]      max_tries_q, max_tries_d;
    logic             exhausted_q, exhausted_d;

    logic [VEC_W-1:0] w_shifted;
    logic [31:0]      w_lfsr_next;
    logic [CNT_W-1:0] w_sol_inc;
    logic [31:0]      w_try_inc;
    logic [CNT_W-1:0] w_new_count;
    logic             w_finish;

    // New LFSR word enters at the LSBs; oldest word falls off the top.
    generate
        if (VEC_W > 32) begin : g_wide
            assign w_shifted = {cand_vec_q[VEC_W-33:0], lfsr_q};
        end else begin : g_narrow
            assign w_shifted = lfsr_q[VEC_W-1:0];
        end
    endgenerate

    assign w_lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ c_LFSR_TAPS) : (lfsr_q >> 1);
    assign w_sol_inc   = (sol_count_q == {CNT_W{1'b1}}) ? sol_count_q
                                                        : sol_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_try_inc   = (try_count_q == 32'hFFFF_FFFF) ? try_count_q : try_count_q + 32'd1;
    assign w_new_count = chk_x ? w_sol_inc : sol_count_q;
    assign w_finish    = (w_new_count == target_q) ||
                         ((max_tries_q != 32'd0) && (try_count_q == max_tries_q));

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        word_cnt_d   = word_cnt_q;
        cand_vec_d   = cand_vec_q;
        cand_valid_d = cand_valid_q;
        sol_vec_d    = sol_vec_q;
        sol_valid_d  = 1'b0;
        sol_count_d  = sol_count_q;
        try_count_d  = try_count_q;
        target_d     = target_q;
        max_tries_d  = max_tries_q;
        exhausted_d  = exhausted_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_d      = (seed == 32'd0) ? 32'd1 : seed;
                    target_d    = target;
                    max_tries_d = max_tries;
                    sol_count_d = '0;
                    try_count_d = '0;
                    exhausted_d = 1'b0;
                    word_cnt_d  = '0;
                    state_d     = (target == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                cand_vec_d = w_shifted;
                lfsr_d     = w_lfsr_next;
                if (word_cnt_q == c_LAST_WORD) begin
                    word_cnt_d   = '0;
                    cand_valid_d = 1'b1;
                    state_d      = S_OFFER;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            S_OFFER: begin
                if (cand_ready) begin
                    try_count_d  = w_try_inc;
                    cand_valid_d = 1'b0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (chk_valid) begin
                    sol_count_d = w_new_count;
                    if (chk_x) begin
                        sol_vec_d   = cand_vec_q;
                        sol_valid_d = 1'b1;
                    end
                    if (w_finish) begin
                        exhausted_d = (w_new_count < target_q);
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lfsr_q       <= '0;
            word_cnt_q   <= '0;
            cand_vec_q   <= '0;
            cand_valid_q <= 1'b0;
            sol_vec_q    <= '0;
            sol_valid_q  <= 1'b0;
            sol_count_q  <= '0;
            try_count_q  <= '0;
            target_q     <= '0;
            max_tries_q  <= '0;
            exhausted_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            word_cnt_q   <= word_cnt_d;
            cand_vec_q   <= cand_vec_d;
            cand_valid_q <= cand_valid_d;
            sol_vec_q    <= sol_vec_d;
            sol_valid_q  <= sol_valid_d;
            sol_count_q  <= sol_count_d;
            try_count_q  <= try_count_d;
            target_q     <= target_d;
            max_tries_q  <= max_tries_d;
            exhausted_q  <= exhausted_d;
        end
    end

    assign cand_vec   = cand_vec_q;
    assign cand_valid = cand_valid_q;
    assign sol_vec    = sol_vec_q;
    assign sol_valid  = sol_valid_q;
    assign sol_count  = sol_count_q;
    assign try_count  = try_count_q;
    assign exhausted  = exhausted_q;
    assign busy       = (state_q == S_FILL) || (state_q == S_OFFER) || (state_q == S_WAIT);
    assign done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_split_sample_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_split_sample_gen
// Description : Directed/randomized self-checking bench for split_sample_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_split_sample_gen;

    localparam int VEC_W = 368;
    localparam int CNT_W = 16;
    localparam int WORDS = 12;

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      seed;
    logic [CNT_W-1:0] target;
    logic [31:0]      max_tries;
    logic [VEC_W-1:0] cand_vec;
    logic             cand_valid;
    logic             cand_ready;
    logic             chk_valid;
    logic             chk_x;
    logic [VEC_W-1:0] sol_vec;
    logic             sol_valid;
    logic [CNT_W-1:0] sol_count;
    logic [31:0]      try_count;
    logic             busy;
    logic             done;
    logic             exhausted;

    int          checks;
    int          errors;
    logic [31:0] m_lfsr;

    split_sample_gen #(.VEC_W(VEC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .target     (target),
        .max_tries  (max_tries),
        .cand_vec   (cand_vec),
        .cand_valid (cand_valid),
        .cand_ready (cand_ready),
        .chk_valid  (chk_valid),
        .chk_x      (chk_x),
        .sol_vec    (sol_vec),
        .sol_valid  (sol_valid),
        .sol_count  (sol_count),
        .try_count  (try_count),
        .busy       (busy),
        .done       (done),
        .exhausted  (exhausted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    // Candidate = 12 consecutive LFSR words, earliest word most significant,
    // truncated to VEC_W bits.
    task automatic gen_cand(output logic [VEC_W-1:0] v);
        int p;
        v = '0;
        for (int k = 0; k < WORDS; k++) begin
            p = 32 * (WORDS - 1 - k);
            for (int b = 0; b < 32; b++)
                if (p + b < VEC_W) v[p + b] = m_lfsr[b];
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chkv({tag, "_cand_vec"}, cand_vec, '0);
        chk1({tag, "_cand_valid"}, cand_valid, 1'b0);
        chkv({tag, "_sol_vec"}, sol_vec, '0);
        chk1({tag, "_sol_valid"}, sol_valid, 1'b0);
        chk32({tag, "_sol_count"}, {16'h0, sol_count}, 32'd0);
        chk32({tag, "_try_count"}, try_count, 32'd0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_exhausted"}, exhausted, 1'b0);
    endtask

    // xmode: 0 = never satisfied, 1 = always, 2 = random.
    // special: 1 = pulse start during first WAIT, 2 = reset during first WAIT.
    task automatic run(input logic [31:0] s, input logic [15:0] tgt, input logic [31:0] mx,
                       input int xmode, input int rdy_lo, input int rdy_hi, input int special,
                       output logic [VEC_W-1:0] first_seen);
        int               m_sol;
        int               m_try;
        bit               m_done;
        logic [VEC_W-1:0] mv;
        int               lat;
        int               d;
        logic             x;
        m_lfsr = (s == 32'd0) ? 32'd1 : s;
        m_sol  = 0;
        m_try  = 0;
        m_done = (tgt == 16'd0);
        first_seen = '0;
        start = 1'b1; seed = s; target = tgt; max_tries = mx;
        @(negedge clk);
        start = 1'b0; seed = $urandom; target = 16'($urandom); max_tries = $urandom;
        if (m_done) begin
            chk1("tgt0_done", done, 1'b1);
            chk32("tgt0_try", try_count, 32'd0);
            chk1("tgt0_exhausted", exhausted, 1'b0);
            return;
        end
        chk1("busy_after_start", busy, 1'b1);
        lat = 1;
        while (!m_done && m_try < 200) begin
            gen_cand(mv);
            while (!cand_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk32("cand_latency", 32'(lat), (m_try == 0) ? 32'd13 : 32'd12);
            if (!cand_valid) return;
            if (m_try == 0) first_seen = cand_vec;
            chkv("cand_vec", cand_vec, mv);
            d = int'($urandom_range(rdy_hi, rdy_lo));
            cand_ready = 1'b0;
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                chk1("offer_hold_valid", cand_valid, 1'b1);
                chkv("offer_hold_vec", cand_vec, mv);
                chk32("offer_hold_try", try_count, 32'(m_try));
            end
            cand_ready = 1'b1;
            @(negedge clk);
            cand_ready = 1'b0;
            m_try++;
            chk1("post_hs_valid", cand_valid, 1'b0);
            chk32("post_hs_try", try_count, 32'(m_try));
            if (special == 1 && m_try == 1) begin
                start = 1'b1; seed = $urandom; target = '0; max_tries = 32'd1;
                @(negedge clk);
                start = 1'b0;
                chk1("start_in_wait_busy", busy, 1'b1);
                chk1("start_in_wait_done", done, 1'b0);
                chk32("start_in_wait_try", try_count, 32'(m_try));
            end
            if (special == 2) begin
                chk_valid = 1'b1; chk_x = 1'b1; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_all_zero("rst_wait");
                @(negedge clk);
                chk_valid = 1'b0; chk_x = 1'b0;
                chk1("late_chk_sol_valid", sol_valid, 1'b0);
                chk32("late_chk_sol_count", {16'h0, sol_count}, 32'd0);
                chk1("late_chk_busy", busy, 1'b0);
                chk1("late_chk_done", done, 1'b0);
                return;
            end
            repeat ($urandom_range(3, 0)) begin
                @(negedge clk);
                chk1("wait_no_sol", sol_valid, 1'b0);
            end
            x = (xmode == 0) ? 1'b0 : (xmode == 1) ? 1'b1 : 1'($urandom_range(1, 0));
            chk_valid = 1'b1; chk_x = x;
            @(negedge clk);
            chk_valid = 1'b0; chk_x = 1'b0;
            if (x) m_sol++;
            m_done = (m_sol == int'(tgt)) || (mx != 32'd0 && m_try == int'(mx));
            chk1("sol_valid", sol_valid, x);
            chk32("sol_count", {16'h0, sol_count}, 32'(m_sol));
            if (x) chkv("sol_vec", sol_vec, mv);
            if (m_done) begin
                chk1("done", done, 1'b1);
                chk1("busy_done", busy, 1'b0);
                chk1("exhausted", exhausted, (m_sol < int'(tgt)));
                @(negedge clk);
                chk1("sol_valid_pulse", sol_valid, 1'b0);
                chk1("done_hold", done, 1'b1);
                chk32("try_hold", try_count, 32'(m_try));
            end else begin
                chk1("busy_refill", busy, 1'b1);
            end
            lat = 0;
        end
    endtask

    initial begin
        logic [VEC_W-1:0] fa;
        logic [VEC_W-1:0] fb;
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; seed = '0; target = '0; max_tries = '0;
        cand_ready = 1'b0; chk_valid = 1'b0; chk_x = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run(32'd1, 16'd1, 32'd0, 1, 0, 0, 0, fa);
        run($urandom, 16'd3, 32'd5, 0, 0, 2, 0, fa);
        run($urandom, 16'd1, 32'd0, 1, 10, 10, 0, fa);
        run(32'd0, 16'd2, 32'd0, 1, 0, 1, 0, fa);
        run(32'd1, 16'd2, 32'd0, 1, 0, 1, 0, fb);
        chkv("seed0_vs_seed1", fa, fb);
        run($urandom, 16'd0, 32'd4, 1, 0, 0, 0, fa);
        run($urandom, 16'd2, 32'd0, 1, 0, 1, 1, fa);
        run($urandom, 16'd3, 32'd2, 1, 0, 1, 0, fa);
        for (int r = 0; r < 4; r++)
            run($urandom, 16'($urandom_range(3, 1)), $urandom_range(6, 0), 2, 0, 3, 0, fa);
        run($urandom, 16'd2, 32'd0, 1, 0, 0, 2, fa);
        run(32'd1, 16'd1, 32'd0, 1, 0, 0, 0, fa);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
